// File: rtl/bus_arbiter.sv
// bus_arbiter: registered round-robin bus arbiter with burst lock, hold-time preemption and CPU stall.
// Optional per-requester statistics when BUS_ARB_STATS_EN is defined.
module bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
`ifdef BUS_ARB_STATS_EN
    input  logic                      stats_clr,
    output logic [NUM_REQ-1:0][15:0]  grant_count,
    output logic [15:0]               max_wait,
`endif
    output logic [NUM_REQ-1:0]        grant,
    output logic [IDW-1:0]            grant_id,
    output logic                      bus_busy,
    output logic                      cpu_stall,
    output logic                      preempt
);
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     id_q, id_d, rr_q, rr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               preempt_q, preempt_d;
    logic [NUM_REQ-1:0] cand;
    logic [IDW-1:0]     win, idx;
    logic               found, take;

    // The current owner is never a candidate, so a preemption scan skips it.
    always_comb begin
        cand  = req & ~grant_q;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(rr_q) + 1 + i) % NUM_REQ);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        rr_d      = rr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        take      = 1'b0;
        if (state_q == IDLE) begin
            take = found;
        end else if (!req[id_q]) begin
            take = found;
            if (!found) begin
                state_d = IDLE;
                grant_d = '0;
            end
        end else if (MAX_HOLD != 0 && hold_q == HOLD_MAX && !lock[id_q] && found) begin
            take      = 1'b1;
            preempt_d = 1'b1;
        end else begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
        if (take) begin
            state_d = OWNED;
            grant_d = NUM_REQ'(1) << win;
            id_d    = win;
            rr_d    = win;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            rr_q      <= IDW'(NUM_REQ - 1);
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant     = grant_q;
    assign grant_id  = id_q;
    assign bus_busy  = (state_q == OWNED);
    assign preempt   = preempt_q;
    assign cpu_stall = req[0] & ~grant_q[0];

`ifdef BUS_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d, wait_q, wait_d;
    logic [15:0]              max_q, max_d;

    // A wait counts every edge a requester is seen pending, including the edge that grants it.
    always_comb begin
        cnt_d = cnt_q;
        max_d = max_q;
        for (int i = 0; i < NUM_REQ; i++)
            wait_d[i] = (req[i] & ~grant_q[i]) ? ((wait_q[i] == 16'hFFFF) ? wait_q[i] : wait_q[i] + 16'd1) : 16'd0;
        if (take) begin
            cnt_d[win]  = (cnt_q[win] == 16'hFFFF) ? cnt_q[win] : cnt_q[win] + 16'd1;
            max_d       = (wait_d[win] > max_q) ? wait_d[win] : max_q;
            wait_d[win] = 16'd0;
        end
        if (stats_clr) begin
            cnt_d  = '0;
            wait_d = '0;
            max_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            cnt_q  <= '0;
            wait_q <= '0;
            max_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wait_q <= wait_d;
            max_q  <= max_d;
        end
    end

    assign grant_count = cnt_q;
    assign max_wait    = max_q;
`endif
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Registered round-robin arbiter for the shared 16-bit data bus.
- Grants exactly one requester at a time, for example CPU microcode, GPU transfer engine, double-dabble readback or a future DMA.
- Supports burst locking and a bounded hold time.
- Produces a stall/halt term that feeds the CPU conditional-halt logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8). Requester 0 is the CPU.
- MAX_HOLD, 16, maximum consecutive owned cycles before preemption is allowed. 0 disables preemption.
- IDW, $clog2(NUM_REQ), width of grant_id.

Ports:
- clk  input  1  system clock (prescaled CPU clock)
- n_reset  input  1  synchronous active-low reset
- req  input  NUM_REQ  request per requester, level; held until done
- lock  input  NUM_REQ  owner asserts to forbid preemption (burst)
- grant  output  NUM_REQ  one-hot grant, registered
- grant_id  output  IDW  index of current owner; valid when bus_busy
- bus_busy  output  1  some requester owns the bus
- cpu_stall  output  1  req[0] & ~grant[0], combinational
- preempt  output  1  one-cycle pulse on a forced handoff

Behaviour:
- Reset (n_reset low at posedge clk): grant=0, grant_id=0, bus_busy=0, preempt=0, hold_cnt=0, rr_ptr=NUM_REQ-1 (so requester 0 wins first), state=IDLE. Reset mid-ownership drops grant on the same edge.
- States: IDLE and OWNED.
- IDLE:
  - If any req is set, the winner is the first set req scanning upward from rr_ptr+1 (mod NUM_REQ).
  - Next edge: grant[w]=1, grant_id=w, bus_busy=1, rr_ptr=w, hold_cnt=0, go to OWNED.
  - Latency from req to grant is 1 cycle.
- OWNED, owner o:
  - req[o] low at the edge: release. If other reqs are pending, the next winner is chosen from rr_ptr+1 and granted on that same edge (zero-bubble handoff). Otherwise go to IDLE and clear grant and bus_busy.
  - req[o] high, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, lock[o] low, and another req pending: preempt. Grant moves to the next winner (o is excluded from the scan), preempt=1 for one cycle, hold_cnt=0.
  - lock[o] high: hold_cnt saturates at MAX_HOLD-1 and no preemption occurs. When lock falls and the other conditions hold, preemption happens on the next edge.
  - Otherwise: hold_cnt increments and saturates at MAX_HOLD-1.
- A single requester with no competition is never preempted, whatever hold_cnt is.
- Simultaneous requests resolve by round-robin order only; there is no fixed priority except immediately after reset.
- Wrap-around: the scan from rr_ptr+1 wraps NUM_REQ-1 -> 0.
- grant is always one-hot or zero. grant_id holds its last value while bus_busy=0.
- lock on a non-owner is ignored.
- req dropped by a non-owner before it is granted: no effect, no grant issued.
- cpu_stall is combinational so the CPU can halt in the same cycle it requests. It is ORed into cpu_halt by the integrator.

Optional Feature:
- Macro: BUS_ARB_STATS_EN.
- Enabled:
  - Adds output grant_count, NUM_REQ x 16 bits: per-requester count of grants issued, saturating at 16'hFFFF.
  - Adds output max_wait, 16 bits: longest cycles any req waited from assertion to grant, saturating.
  - Adds input stats_clr, 1 bit: synchronous clear of all counters, which takes priority over increments on the same edge.
  - All stats reset to 0 on n_reset.
- Disabled: these ports and counters do not exist. Arbitration is cycle-identical to the enabled build.

Test Plan:
1. Reset release, req=4'b0001: grant=0001 one cycle later, bus_busy=1, grant_id=0, cpu_stall=1 for exactly 1 cycle.
2. req=4'b1111 held, each owner releases after 2 cycles: grant order 0,1,2,3,0 with zero idle cycles between owners.
3. MAX_HOLD=4, req=4'b0011 held, lock=0: owner 0 is preempted after 4 owned cycles, preempt pulses once, and grants alternate 0/1 every 4 cycles.
4. Same as scenario 3 but lock[0]=1 for 10 cycles: no preemption while locked. Handoff to 1 occurs on the edge after lock falls.
5. Owner 2 active, n_reset pulsed low for 1 cycle: grant=0 and bus_busy=0 at that edge. After release with req=4'b0101, requester 0 is granted first.
6. BUS_ARB_STATS_EN, scenario 2 for 8 grants: grant_count for each requester = 2. Then stats_clr=1 for 1 cycle: all counters read 0.
